// File: rtl/obi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// obi_rr_arbiter
//   Round-robin arbiter sharing one OBI master port among NUM_REQ CGRA
//   memory-node masters. Granted transactions are recorded in an in-order
//   owner FIFO so each rvalid/rdata is routed back to the issuing node.
//
// Parameters
//   NUM_REQ  number of node ports (default 9)
//   MAX_OUT  max outstanding transactions / owner FIFO depth (>=1, default 2)
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i/req_addr_i/req_we_i/req_be_i/req_wdata_i
//                         per-node OBI request channel
//   resp_gnt_o/resp_rvalid_o/resp_rdata_o
//                         per-node OBI response channel (rdata broadcast)
//   bus_req_o/bus_addr_o/bus_we_o/bus_be_o/bus_wdata_o
//                         shared bus request channel
//   bus_gnt_i/bus_rvalid_i/bus_rdata_i
//                         shared bus response channel
//   err_o                 sticky: rvalid seen with owner FIFO empty
//   stall_cycles_o        stall counter, built only with OBI_ARB_STALL_CTR_EN
//                         (tied to 0 otherwise)
// ---------------------------------------------------------------------------

// Per-node response lane: decodes grant and rvalid for one node index.
module obi_rr_lane #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned LANE  = 0
) (
  input  logic             hs_i,
  input  logic [IDX_W-1:0] win_i,
  input  logic             pop_i,
  input  logic [IDX_W-1:0] head_i,
  input  logic [31:0]      bus_rdata_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o
);
  assign gnt_o    = hs_i  & (win_i  == IDX_W'(LANE));
  assign rvalid_o = pop_i & (head_i == IDX_W'(LANE));
  assign rdata_o  = bus_rdata_i;
endmodule

module obi_rr_arbiter #(
  parameter int unsigned NUM_REQ = 9,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // node requests
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0][31:0]      req_addr_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ-1:0][3:0]       req_be_i,
  input  logic [NUM_REQ-1:0][31:0]      req_wdata_i,
  // node responses
  output logic [NUM_REQ-1:0]            resp_gnt_o,
  output logic [NUM_REQ-1:0]            resp_rvalid_o,
  output logic [NUM_REQ-1:0][31:0]      resp_rdata_o,
  // shared bus
  output logic                          bus_req_o,
  output logic [31:0]                   bus_addr_o,
  output logic                          bus_we_o,
  output logic [3:0]                    bus_be_o,
  output logic [31:0]                   bus_wdata_o,
  input  logic                          bus_gnt_i,
  input  logic                          bus_rvalid_i,
  input  logic [31:0]                   bus_rdata_i,
  // status
  output logic                          err_o,
  output logic [31:0]                   stall_cycles_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic                          locked_q, locked_d;
  logic [IDX_W-1:0]              lock_idx_q, lock_idx_d;
  logic                          err_q, err_d;
  logic [MAX_OUT-1:0][IDX_W-1:0] owner_q;
  logic [PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [IDX_W-1:0] scan_idx, win_idx, head_idx;
  logic             scan_found;
  logic             fifo_full, fifo_empty;
  logic             hs, pop, spurious;
  int unsigned      cand;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    scan_idx   = rr_ptr_q;
    scan_found = 1'b0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!scan_found && req_i[IDX_W'(cand)]) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(cand);
      end
    end
  end

  // A stalled address phase must not change master, so the lock overrides the scan.
  assign win_idx    = locked_q ? lock_idx_q : scan_idx;
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUT));
  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = owner_q[rd_ptr_q];

  assign bus_req_o   = ~rst_i & req_i[win_idx] & ~fifo_full;
  assign bus_addr_o  = req_addr_i[win_idx];
  assign bus_we_o    = req_we_i[win_idx];
  assign bus_be_o    = req_be_i[win_idx];
  assign bus_wdata_o = req_wdata_i[win_idx];

  assign hs       = bus_req_o & bus_gnt_i;
  assign pop      = ~rst_i & bus_rvalid_i & ~fifo_empty;
  assign spurious = bus_rvalid_i & fifo_empty;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | spurious;
    // Lock holds exactly while a request is presented but not yet granted.
    locked_d   = bus_req_o & ~bus_gnt_i;
    lock_idx_d = win_idx;
    if (hs) rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      owner_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      if (hs) begin
        owner_q[wr_ptr_q] <= win_idx;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  assign err_o = err_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    obi_rr_lane #(
      .IDX_W (IDX_W),
      .LANE  (g)
    ) u_lane (
      .hs_i        (hs),
      .win_i       (win_idx),
      .pop_i       (pop),
      .head_i      (head_idx),
      .bus_rdata_i (bus_rdata_i),
      .gnt_o       (resp_gnt_o[g]),
      .rvalid_o    (resp_rvalid_o[g]),
      .rdata_o     (resp_rdata_o[g])
    );
  end

`ifdef OBI_ARB_STALL_CTR_EN
  logic [31:0] stall_q, stall_d;

  // Counts cycles where someone wants the bus but no transfer happens.
  always_comb begin
    stall_d = stall_q;
    if ((|req_i) && !hs && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_obi_rr_arbiter
//   Directed-vector bench for obi_rr_arbiter (NUM_REQ=9, MAX_OUT=2).
//   Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// ---------------------------------------------------------------------------
module tb_obi_rr_arbiter;
  localparam int N = 9;

  logic              clk, rst;
  logic [N-1:0]      req;
  logic [N-1:0][31:0] addr;
  logic [N-1:0]      we;
  logic [N-1:0][3:0] be;
  logic [N-1:0][31:0] wdata;
  logic [N-1:0]      gnt_o, rvalid_o;
  logic [N-1:0][31:0] rdata_o;
  logic              bus_req, bus_we;
  logic [31:0]       bus_addr, bus_wdata;
  logic [3:0]        bus_be;
  logic              gnt, rvalid;
  logic [31:0]       rdata;
  logic              err;
  logic [31:0]       stall;

  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] oh;

  obi_rr_arbiter #(.NUM_REQ(N), .MAX_OUT(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .req_addr_i(addr), .req_we_i(we), .req_be_i(be), .req_wdata_i(wdata),
    .resp_gnt_o(gnt_o), .resp_rvalid_o(rvalid_o), .resp_rdata_o(rdata_o),
    .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_we_o(bus_we), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata),
    .err_o(err), .stall_cycles_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      addr[k]  = 32'hA000_0000 + 32'(k) * 32'h10;
      we[k]    = 1'b0;
      be[k]    = 4'hF;
      wdata[k] = 32'h1111_0000 + 32'(k);
    end
    addr[3] = 32'h0000_1000;

    // reset: outputs forced low even with activity on the inputs
    idle(); rst = 1'b1;
    tick();
    req = '1; gnt = 1'b1; rvalid = 1'b1;
    #1;
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    tick();
    idle(); rst = 1'b0;
    #1;
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // single requester, node 3
    req[3] = 1'b1; we[3] = 1'b1; wdata[3] = 32'h5555_AAAA; gnt = 1'b1;
    #1;
    chk("t1_bus_req", 64'(bus_req), 64'd1);
    chk("t1_addr", 64'(bus_addr), 64'h1000);
    chk("t1_we", 64'(bus_we), 64'd1);
    chk("t1_wdata", 64'(bus_wdata), 64'h5555_AAAA);
    chk("t1_gnt", 64'(gnt_o), 64'h008);
    tick();
    req = '0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_rvalid", 64'(rvalid_o), 64'h008);
    chk("t1_rdata", 64'(rdata_o[3]), 64'hDEAD_BEEF);
    chk("t1_no_gnt", 64'(gnt_o), 64'd0);
    tick();
    // rr_ptr now 4: node 5 beats node 0
    rvalid = 1'b0; req = 9'h021; gnt = 1'b1;
    #1;
    chk("t1_rrptr4", 64'(gnt_o), 64'h020);
    chk("t1_rrptr4_addr", 64'(bus_addr), 64'(addr[5]));
    tick();
    req = 9'h001;
    #1;
    chk("t1_wrap_gnt", 64'(gnt_o), 64'h001);
    tick();
    req = '0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1;
    #1;
    chk("t1_route5", 64'(rvalid_o), 64'h020);
    tick();
    rdata = 32'h2;
    #1;
    chk("t1_route0", 64'(rvalid_o), 64'h001);
    tick();

    // all nodes request, gnt every cycle, response one cycle later
    do_reset();
    for (int i = 0; i <= 9; i++) begin
      req = '1; gnt = 1'b1; rvalid = (i > 0); rdata = 32'hC0DE_0000 + 32'(i);
      #1;
      oh = 9'b1 << (i % 9);
      chk("t2_order", 64'(gnt_o), 64'(oh));
      if (i > 0) begin
        oh = 9'b1 << ((i - 1) % 9);
        chk("t2_route", 64'(rvalid_o), 64'(oh));
      end
      tick();
    end
    req = '0; gnt = 1'b0; rvalid = 1'b1;
    #1;
    chk("t2_route_last", 64'(rvalid_o), 64'h001);
    tick();

    // lock: nodes 2 and 5, bus stalls 3 cycles, then node 0 joins
    do_reset();
    req = 9'h024; gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_addr_stable", 64'(bus_addr), 64'(addr[2]));
      chk("t3_req_held", 64'(bus_req), 64'd1);
      tick();
    end
    req = 9'h025; gnt = 1'b1;
    #1;
    chk("t3_lock_gnt", 64'(gnt_o), 64'h004);
    chk("t3_lock_addr", 64'(bus_addr), 64'(addr[2]));
    tick();
    req = '0; gnt = 1'b0; rvalid = 1'b1;
    #1;
    chk("t3_route2", 64'(rvalid_o), 64'h004);
    tick();

    // backpressure with MAX_OUT=2 (rr_ptr=3)
    rvalid = 1'b0; req = 9'h010; gnt = 1'b1;
    #1;
    chk("t4_gnt4", 64'(gnt_o), 64'h010);
    tick();
    req = 9'h040;
    #1;
    chk("t4_gnt6", 64'(gnt_o), 64'h040);
    tick();
    req = 9'h080;
    #1;
    chk("t4_full_req", 64'(bus_req), 64'd0);
    chk("t4_full_gnt", 64'(gnt_o), 64'd0);
    tick();
    rvalid = 1'b1;
    #1;
    chk("t4_full_pop_req", 64'(bus_req), 64'd0);
    chk("t4_route4", 64'(rvalid_o), 64'h010);
    tick();
    rvalid = 1'b0;
    #1;
    chk("t4_fwd_req", 64'(bus_req), 64'd1);
    chk("t4_gnt7", 64'(gnt_o), 64'h080);
    tick();
    req = '0; gnt = 1'b0; rvalid = 1'b1;
    #1;
    chk("t4_route6", 64'(rvalid_o), 64'h040);
    tick();
    #1;
    chk("t4_route7", 64'(rvalid_o), 64'h080);
    tick();

    // spurious rvalid with empty FIFO
    #1;
    chk("t5_no_rvalid", 64'(rvalid_o), 64'd0);
    tick();
    rvalid = 1'b0;
    #1;
    chk("t5_err_set", 64'(err), 64'd1);
    tick(); tick();
    chk("t5_err_held", 64'(err), 64'd1);
    do_reset();
    #1;
    chk("t5_err_clr", 64'(err), 64'd0);

    // stall counter: request held 4 cycles before gnt
    do_reset();
    req = 9'h002; gnt = 1'b0;
    repeat (4) tick();
    gnt = 1'b1;
    #1;
    chk("t6_gnt1", 64'(gnt_o), 64'h002);
    tick();
    req = '0; gnt = 1'b0;
    #1;
`ifdef OBI_ARB_STALL_CTR_EN
    chk("t6_stall", 64'(stall), 64'd4);
`else
    chk("t6_stall", 64'(stall), 64'd0);
`endif
    do_reset();
    #1;
    chk("t6_stall_rst", 64'(stall), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/obi_rr_arbiter.md
# obi_rr_arbiter

Round-robin arbiter that shares one OBI master port among `NUM_REQ` CGRA memory-node OBI masters (input, output and config nodes). It is placed between the node master ports and a single system-bus port. It tracks outstanding transactions in an in-order owner FIFO and routes each `rvalid`/`rdata` back to the node that issued the request.

## Interface
Parameters:
- `NUM_REQ`, default 9: number of requesting node ports.
- `MAX_OUT`, default 2: maximum outstanding (granted, not yet responded) transactions; owner-FIFO depth, ≥1.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `req_i`, input, `obi_req_t [NUM_REQ]`: node requests (`req`, `addr`, `we`, `be`, `wdata`).
- `resp_o`, output, `obi_resp_t [NUM_REQ]`: per-node `gnt`, `rvalid`, `rdata`.
- `bus_req_o`, output, `obi_req_t`: shared bus request.
- `bus_resp_i`, input, `obi_resp_t`: shared bus response.
- `err_o`, output, 1: sticky flag; set when an `rvalid` arrives with the owner FIFO empty.
- `stall_cycles_o`, output, 32: stall counter (see Configuration).

## Operation
- Candidates: nodes with `req_i[k].req=1`. The winner is the first candidate at or after `rr_ptr`, scanning upward modulo `NUM_REQ`.
- Lock: when `bus_req_o.req=1` and `bus_resp_i.gnt=0`, the winner index is registered in `lock_idx` and `locked` is set. While `locked`, the winner is `lock_idx` regardless of other requests, which keeps OBI address-phase stability. `locked` clears on the cycle `gnt` is taken.
- `bus_req_o`: the winner's request fields when `req_i[win].req=1` and the FIFO is not full. Otherwise `bus_req_o.req=0` and the other fields are don't-care (driven from `req_i[win]`).
- `resp_o[win].gnt = bus_resp_i.gnt & bus_req_o.req`. All other `gnt` outputs are 0.
- On handshake (`bus_req_o.req & bus_resp_i.gnt`):
  - push `win` into the FIFO;
  - `rr_ptr <= (win+1) mod NUM_REQ`;
  - clear the lock.
- On `bus_resp_i.rvalid`:
  - `resp_o[head].rvalid=1` and `resp_o[head].rdata=bus_resp_i.rdata`;
  - pop the FIFO.
  - All other `rvalid` outputs are 0. `rdata` is broadcast to all nodes.
- Simultaneous push and pop: both take effect and the count is unchanged.
- Full FIFO: new requests are blocked, even if a pop happens in the same cycle.
- `rvalid` with the FIFO empty: no node sees `rvalid`, nothing is popped, and `err_o` is set to 1 until reset.
- A requester that drops `req` while not locked is dropping a legal non-granted request; it is simply no longer a candidate.

## Timing
- Request path is combinational, zero latency: `req_i` → `bus_req_o` → `gnt` → `resp_o.gnt` in the same cycle.
- Response routing is combinational from the FIFO head. A response may arrive at the earliest in the cycle after its grant, since the push is registered.
- Reset, on the rising edge with `rst_i=1`:
  - `rr_ptr=0`, `locked=0`, FIFO empty, `err_o=0`, `stall_cycles_o=0`.
- While `rst_i=1`, the following are forced to 0:
  - `bus_req_o.req`;
  - all `resp_o[*].gnt`;
  - all `resp_o[*].rvalid`.
- Reset mid-transaction: outstanding owner records are discarded. The integrating logic resets the bus slave together with this block.
- Fairness: a continuously requesting node is granted within `NUM_REQ` bus grants.

## Configuration
- Macro `OBI_ARB_STALL_CTR_EN`.
- Defined: `stall_cycles_o` is a 32-bit register.
  - Increments, saturating at `0xFFFF_FFFF`, in each cycle where any `req_i[k].req=1` and no handshake occurs.
  - Cleared by reset.
- Undefined: the counter logic is not compiled and `stall_cycles_o` is tied to `'0`.

## Test plan
- Single requester: node 3 requests `addr=0x1000`, bus grants immediately, `rvalid` follows one cycle later with `rdata=0xDEADBEEF`.
  - Required: `resp_o[3].gnt` in the same cycle, then `resp_o[3].rvalid` with `0xDEADBEEF`.
  - Required: `rr_ptr=4`.
- All 9 nodes request continuously, bus `gnt=1` every cycle, responses one cycle later.
  - Required: grant order 0,1,…,8,0.
  - Required: each `rvalid` is routed to the matching issuer.
- Lock: nodes 2 and 5 request with `rr_ptr=0`, and bus holds `gnt=0` for 3 cycles.
  - Required: `bus_req_o.addr` stays at node 2's address.
  - Then node 0 asserts `req`, and `gnt` is given: the grant goes to node 2, not node 0.
- `MAX_OUT=2` backpressure: two grants are issued with no `rvalid`.
  - Required: `bus_req_o.req=0` while a third node requests.
  - Then one `rvalid` arrives: the next cycle the third request is forwarded.
- A spurious `rvalid` with the FIFO empty.
  - Required: no `resp_o[*].rvalid`, and `err_o=1` held until `rst_i`.
- With `OBI_ARB_STALL_CTR_EN` defined: a request is held 4 cycles before `gnt`.
  - Required: `stall_cycles_o=4`.
  - After `rst_i`: `stall_cycles_o=0`.
